// File: rtl/serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// serial_compare_ctrl
//   Sequencer for an external 1-bit magnitude comparator. Captures a WIDTH-bit
//   operand pair on a valid/ready handshake, walks the pair MSB-first through
//   the shared comparator (one bit per clock) and returns the result plus the
//   number of bits examined on a second valid/ready handshake.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready high only in IDLE
//   a, b                operands (WIDTH bits)
//   bit_a, bit_b        current MSB of the operand shift registers, to comparator
//   bit_gt/lt/eq        comparator outputs, sampled every CMP clock
//   out_valid/out_ready result handshake
//   greater/lesser/equal result flags (exactly one high when err=0)
//   err                 comparator reported not-exactly-one of gt/lt/eq
//   cycles              bits examined, 1..WIDTH (CW bits)
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1,
  parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             bit_gt,
  input  logic             bit_lt,
  input  logic             bit_eq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             lesser,
  output logic             equal,
  output logic             err,
  output logic [CW-1:0]    cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             err_q, err_d;
  logic             diff_q, diff_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [2:0]       cmp_vec_c;
  logic             onehot_c;
  logic             differ_c;
  logic [CW-1:0]    cnt_inc_c;
  logic             last_c;

  // Comparator sanity and bit-position decode
  always_comb begin
    cmp_vec_c = {bit_gt, bit_lt, bit_eq};
    onehot_c  = (cmp_vec_c == 3'b100) || (cmp_vec_c == 3'b010) ||
                (cmp_vec_c == 3'b001);
    differ_c  = bit_gt || bit_lt;
    cnt_inc_c = cnt_q + CW'(1);
    last_c    = (cnt_inc_c == CW'(WIDTH));
  end

  // Next-state and result logic
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    err_d   = err_q;
    diff_d  = diff_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sh_a_d  = a;
          sh_b_d  = b;
          cnt_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          err_d   = 1'b0;
          diff_d  = 1'b0;
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        cnt_d = cnt_inc_c;
        if (!onehot_c) begin
          err_d   = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = S_DONE;
        end else if (differ_c && (EARLY_EXIT != 0)) begin
          gt_d    = bit_gt;
          lt_d    = bit_lt;
          state_d = S_DONE;
        end else begin
          // Full scan: only the first differing bit decides the result
          if (differ_c && !diff_q) begin
            gt_d   = bit_gt;
            lt_d   = bit_lt;
            diff_d = 1'b1;
          end
          if (last_c) begin
            eq_d    = !(diff_q || differ_c);
            state_d = S_DONE;
          end else begin
            sh_a_d = sh_a_q << 1;
            sh_b_d = sh_b_q << 1;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      cnt_q       <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      err_q       <= 1'b0;
      diff_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      cnt_q       <= cnt_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      err_q       <= err_d;
      diff_q      <= diff_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bit_a     = sh_a_q[WIDTH-1];
  assign bit_b     = sh_b_q[WIDTH-1];
  assign greater   = gt_q;
  assign lesser    = lt_q;
  assign equal     = eq_q;
  assign err       = err_q;
  assign cycles    = cnt_q;

endmodule
